// File: rtl/alu_wb_unit.sv
// alu_wb_unit: execute/writeback stage behind the 32x32 register bank.
// It accepts two operands, an opcode and a destination index with a
// valid/ready handshake. It performs one ALU operation and then drives the
// register bank write port with a one-cycle pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      accept handshake; in_ready is high only in IDLE
//   op, sr1_data, sr2_data   opcode, operand A, operand B
//   dst                      destination register index
//   wr_en, wr_addr, wr_data  register bank write port (wr_en pulses once per op)
//   busy                     unit is not idle
//   illegal                  one-cycle pulse after an undefined opcode is accepted
//
// Build option: define MUL_EN to build the multi-cycle shift-add multiplier
// for opcode 8. Without it, opcode 8 is reported as illegal.
module alu_wb_unit #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [DW-1:0] sr1_data,
    input  logic [DW-1:0] sr2_data,
    input  logic [AW-1:0] dst,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          illegal
);

    localparam int unsigned SHW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB
`ifdef MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          busy_q;
    logic          illegal_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [DW-1:0] alu_res_d;
    logic          op_alu_c;

`ifdef MUL_EN
    logic [DW-1:0]  mul_a_q;
    logic [DW-1:0]  mul_b_q;
    logic [DW-1:0]  mul_acc_q;
    logic [DW-1:0]  mul_acc_d;
    logic [SHW-1:0] mul_cnt_q;
    logic [AW-1:0]  mul_dst_q;

    // One shift-add step: add the (pre-shifted) multiplicand when the multiplier LSB is set.
    assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
`endif

    assign op_alu_c = (op < 4'd8);

    // Single-cycle ALU result, computed from the live inputs and captured at the accept edge.
    always_comb begin
        alu_res_d = '0;
        case (op)
            4'd0:    alu_res_d = sr1_data + sr2_data;
            4'd1:    alu_res_d = sr1_data - sr2_data;
            4'd2:    alu_res_d = sr1_data & sr2_data;
            4'd3:    alu_res_d = sr1_data | sr2_data;
            4'd4:    alu_res_d = sr1_data ^ sr2_data;
            4'd5:    alu_res_d = ($signed(sr1_data) < $signed(sr2_data)) ? DW'(1) : '0;
            4'd6:    alu_res_d = sr1_data << sr2_data[SHW-1:0];
            4'd7:    alu_res_d = sr1_data >> sr2_data[SHW-1:0];
            default: alu_res_d = '0;
        endcase
    end

    // Control FSM with registered handshake, status and write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            illegal_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef MUL_EN
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_acc_q  <= '0;
            mul_cnt_q  <= '0;
            mul_dst_q  <= '0;
`endif
        end else begin
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op_alu_c) begin
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= dst;
                            wr_data_q  <= alu_res_d;
                            state_q    <= S_WB;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
`ifdef MUL_EN
                        else if (op == 4'd8) begin
                            mul_a_q    <= sr1_data;
                            mul_b_q    <= sr2_data;
                            mul_acc_q  <= '0;
                            mul_cnt_q  <= '0;
                            mul_dst_q  <= dst;
                            state_q    <= S_MUL;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
`endif
                        else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
`ifdef MUL_EN
                S_MUL: begin
                    // Fixed DW iterations regardless of operand values.
                    mul_acc_q <= mul_acc_d;
                    mul_a_q   <= mul_a_q << 1;
                    mul_b_q   <= mul_b_q >> 1;
                    mul_cnt_q <= mul_cnt_q + SHW'(1);
                    if (mul_cnt_q == SHW'(DW - 1)) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= mul_dst_q;
                        wr_data_q <= mul_acc_d;
                        state_q   <= S_WB;
                    end
                end
`endif
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign illegal  = illegal_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_alu_wb_unit.sv
// Directed bench for alu_wb_unit: reset, ALU ops, multiplier, illegal ops, reset abort.
module tb_alu_wb_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] sr1_data;
    logic [31:0] sr2_data;
    logic [4:0]  dst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        illegal;

    int total;
    int bad;

    alu_wb_unit #(.DW(32), .AW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .sr1_data (sr1_data),
        .sr2_data (sr2_data),
        .dst      (dst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle ALU op and check the writeback pulse and the return to IDLE.
    task automatic alu_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        op = o; sr1_data = a; sr2_data = b; dst = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sr1_data = 32'hDEAD_BEEF; sr2_data = 32'h1234_5678; dst = 5'd31; op = 4'd0;
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(d));
        chk({tag, "_wr_data"}, wr_data, exp);
        chk({tag, "_in_ready_wb"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_wr_en_off"}, 32'(wr_en), 32'd0);
        chk({tag, "_hold_data"}, wr_data, exp);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int wait_cnt;
        int wr_cnt;
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; sr1_data = '0; sr2_data = '0; dst = '0;

        // Reset
        #1 rst = 1'b0;
        #2;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #3 rst = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // ALU ops
        alu_op("add", 4'd0, 32'd30, 32'd40, 5'd7, 32'd70);
        alu_op("sub", 4'd1, 32'd5, 32'd6, 5'd1, 32'hFFFF_FFFF);
        alu_op("and", 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd2, 32'h00F0_000F);
        alu_op("or", 4'd3, 32'hF000_0001, 32'h0000_0F00, 5'd4, 32'hF000_0F01);
        alu_op("xor", 4'd4, 32'hFFFF_0000, 32'hF0F0_F0F0, 5'd5, 32'h0F0F_F0F0);
        alu_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd0, 5'd6, 32'd1);
        alu_op("slt_pos", 4'd5, 32'd0, 32'hFFFF_FFFF, 5'd6, 32'd0);
        alu_op("sll", 4'd6, 32'd1, 32'd4, 5'd8, 32'd16);
        alu_op("sll_wrapamt", 4'd6, 32'd1, 32'd35, 5'd9, 32'd8);
        alu_op("srl", 4'd7, 32'h8000_0000, 32'd31, 5'd10, 32'd1);
        alu_op("add_wrap_r0", 4'd0, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1);

        // Illegal opcode
        op = 4'd12; sr1_data = 32'd1; sr2_data = 32'd1; dst = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill12_pulse", 32'(illegal), 32'd1);
        chk("ill12_no_wr", 32'(wr_en), 32'd0);
        chk("ill12_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ill12_pulse_end", 32'(illegal), 32'd0);
        chk("ill12_no_wr2", 32'(wr_en), 32'd0);
        chk("ill12_hold", wr_data, 32'd1);

`ifdef MUL_EN
        // Multiply with a stray in_valid pulse while busy
        op = 4'd8; sr1_data = 32'd1000; sr2_data = 32'd3000; dst = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sr1_data = 32'd7; sr2_data = 32'd7;
        busy_cnt = 0; wait_cnt = 0;
        while (wr_en !== 1'b1 && wait_cnt < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (wait_cnt == 5) begin op = 4'd0; dst = 5'd9; in_valid = 1'b1; end
            if (wait_cnt == 6) in_valid = 1'b0;
            tick();
            wait_cnt++;
        end
        if (busy === 1'b1) busy_cnt++;
        chk("mul_latency", 32'(wait_cnt), 32'd32);
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("mul_wr_addr", 32'(wr_addr), 32'd3);
        chk("mul_wr_data", wr_data, 32'd3000000);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_en === 1'b1) wr_cnt++;
        end
        chk("mul_extra_writes", 32'(wr_cnt), 32'd0);
        chk("mul_idle_ready", 32'(in_ready), 32'd1);

        // Reset ten cycles into a multiply aborts it
        op = 4'd8; sr1_data = 32'd12; sr2_data = 32'd13; dst = 5'd11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_wr_data", wr_data, 32'd0);
        rst = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_en === 1'b1) wr_cnt++;
        end
        chk("abort_no_write", 32'(wr_cnt), 32'd0);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);
`else
        // Without the multiplier, opcode 8 is illegal
        op = 4'd8; sr1_data = 32'd1000; sr2_data = 32'd3000; dst = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill8_pulse", 32'(illegal), 32'd1);
        chk("ill8_no_wr", 32'(wr_en), 32'd0);
        chk("ill8_busy", 32'(busy), 32'd0);
        tick();
        chk("ill8_pulse_end", 32'(illegal), 32'd0);
        chk("ill8_no_wr2", 32'(wr_en), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
